// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and default parameters for the memory port arbiter
// Purpose: owner encoding, response tag layout, default parameter values.
package mem_arb_pkg;

    localparam int DEF_ADDR_W       = 32;
    localparam int DEF_DATA_W       = 32;
    localparam int DEF_MEM_LATENCY  = 1;
    localparam int DEF_STARVE_LIMIT = 4;

    typedef enum logic {
        OWNER_IF = 1'b0,
        OWNER_DM = 1'b1
    } mem_owner_t;

    typedef struct packed {
        logic       valid;
        mem_owner_t owner;
    } mem_tag_t;

endpackage

// File: rtl/mem_arb_tag_pipe.sv
// rtl/mem_arb_tag_pipe.sv - shift register of read tags matching the memory latency
// Purpose: carries {valid, owner} of each issued read so the response can be routed.
// Ports:
//   clk, rst    - clock, synchronous active-low reset (clears all stages)
//   tag_in      - tag loaded into stage 0 every cycle
//   tag_out     - final-stage tag, aligned with mem_rdata
module mem_arb_tag_pipe
    import mem_arb_pkg::*;
#(
    parameter int MEM_LATENCY = DEF_MEM_LATENCY
) (
    input  logic     clk,
    input  logic     rst,
    input  mem_tag_t tag_in,
    output mem_tag_t tag_out
);

    mem_tag_t [MEM_LATENCY-1:0] stage_q;
    mem_tag_t [MEM_LATENCY-1:0] stage_d;

    always_comb begin
        stage_d[0] = tag_in;
        for (int i = 1; i < MEM_LATENCY; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign tag_out = stage_q[MEM_LATENCY-1];

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/data arbiter in front of one pipelined fixed-latency RAM
// Purpose: data port wins by default; a saturating starvation counter forces a fetch
// grant after STARVE_LIMIT consecutive data grants. Read responses are routed back
// to their issuer through a tag pipeline.
// Ports:
//   clk, rst                          - clock, synchronous active-low reset
//   if_req/if_addr/if_gnt             - fetch read request handshake
//   if_rvalid/if_rdata                - fetch read response
//   dm_req/dm_wen/dm_wstrb/dm_addr/
//   dm_wdata/dm_gnt                   - data request handshake
//   dm_rvalid/dm_rdata                - data read response
//   mem_en/mem_wen/mem_wstrb/
//   mem_addr/mem_wdata/mem_rdata      - memory issue and read data
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int MEM_LATENCY  = DEF_MEM_LATENCY,
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_wen,
    input  logic [3:0]        dm_wstrb,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic              dm_rvalid,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_en,
    output logic              mem_wen,
    output logic [3:0]        mem_wstrb,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    logic [3:0] starve_cnt_q;
    logic [3:0] starve_cnt_d;
    logic       dm_write;
    mem_tag_t   tag_in;
    mem_tag_t   tag_out;

    // Grants are gated by rst so nothing issues while reset is held.
    always_comb begin
        if_gnt = 1'b0;
        dm_gnt = 1'b0;
        if (rst) begin
            if (if_req && (!dm_req || starve_cnt_q == STARVE_MAX)) begin
                if_gnt = 1'b1;
            end else if (dm_req) begin
                dm_gnt = 1'b1;
            end
        end
    end

    always_comb begin
        dm_write  = dm_gnt && dm_wen;
        mem_en    = if_gnt || dm_gnt;
        mem_wen   = dm_write;
        mem_wstrb = dm_write ? dm_wstrb : 4'h0;
        mem_wdata = dm_write ? dm_wdata : '0;
        mem_addr  = '0;
        if (if_gnt) begin
            mem_addr = if_addr;
        end else if (dm_gnt) begin
            mem_addr = dm_addr;
        end
    end

    // Counts data grants that made a waiting fetch lose; any cycle without a
    // waiting fetch restarts the count.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!if_req || if_gnt) begin
            starve_cnt_d = 4'h0;
        end else if (dm_gnt && starve_cnt_q < STARVE_MAX) begin
            starve_cnt_d = starve_cnt_q + 4'h1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            starve_cnt_q <= 4'h0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

    always_comb begin
        tag_in.valid = mem_en && !dm_write;
        tag_in.owner = if_gnt ? OWNER_IF : OWNER_DM;
    end

    mem_arb_tag_pipe #(
        .MEM_LATENCY (MEM_LATENCY)
    ) u_tag_pipe (
        .clk     (clk),
        .rst     (rst),
        .tag_in  (tag_in),
        .tag_out (tag_out)
    );

    // A response surfacing during reset belongs to a dropped read and is hidden.
    always_comb begin
        if_rvalid = rst && tag_out.valid && (tag_out.owner == OWNER_IF);
        dm_rvalid = rst && tag_out.valid && (tag_out.owner == OWNER_DM);
        if_rdata  = if_rvalid ? mem_rdata : '0;
        dm_rdata  = dm_rvalid ? mem_rdata : '0;
    end

endmodule
